// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RISC-V core: one state register, with
// mux selects and write strobes decoded from the current state, IR fields and ALU flags.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opc,
  input  logic [2:0] f3,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       PC_write,
  output logic       IR_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] ALU_src_A,
  output logic [1:0] ALU_src_B,
  output logic [1:0] ALU_op,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BT   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_EXEC_R,
    S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR_ADR, S_JALR_J, S_LUI
  } state_t;

  state_t state, state_next;

  // NOTE: sequential state uses non-blocking assignment so every flop updates
  // from the values that existed before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves a
    // value unassigned and no latch is inferred.
    state_next = S_FETCH;
    PC_write   = 1'b0;
    IR_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    ALU_src_A  = 2'b00;
    ALU_src_B  = 2'b00;
    ALU_op     = 2'b00;
    result_src = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (opc)
      OP_SW:   imm_src = 3'b001;
      OP_BT:   imm_src = 3'b010;
      OP_LUI:  imm_src = 3'b011;
      OP_JAL:  imm_src = 3'b100;
      default: imm_src = 3'b000;
    endcase

    case (state)
      S_FETCH: begin
        ALU_src_B  = 2'b10;
        result_src = 2'b10;
        IR_write   = mem_ready;
        PC_write   = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALU_src_A = 2'b01;
        ALU_src_B = 2'b01;
        case (opc)
          OP_LW, OP_SW: state_next = S_MEM_ADR;
          OP_R:         state_next = S_EXEC_R;
          OP_I:         state_next = S_EXEC_I;
          OP_BT:        state_next = S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          OP_JALR:      state_next = S_JALR_ADR;
          OP_LUI:       state_next = S_LUI;
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEM_ADR: begin
        ALU_src_A  = 2'b10;
        ALU_src_B  = 2'b01;
        state_next = (opc == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        adr_src    = 1'b1;
        state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
        state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXEC_R: begin
        ALU_src_A  = 2'b10;
        ALU_op     = 2'b10;
        state_next = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALU_src_A  = 2'b10;
        ALU_src_B  = 2'b01;
        ALU_op     = 2'b11;
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALU_src_A  = 2'b10;
        ALU_op     = 2'b01;
        instr_done = 1'b1;
        case (f3)
          3'b000:  PC_write = zero;
          3'b001:  PC_write = ~zero;
          3'b100:  PC_write = neg;
          3'b101:  PC_write = ~neg;
          default: PC_write = 1'b0;
        endcase
      end
      S_JAL, S_JALR_J: begin
        ALU_src_A  = 2'b01;
        ALU_src_B  = 2'b10;
        PC_write   = 1'b1;
        state_next = S_ALU_WB;
      end
      S_JALR_ADR: begin
        ALU_src_A  = 2'b10;
        ALU_src_B  = 2'b01;
        state_next = S_JALR_J;
      end
      S_LUI: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase

    // The state already reads FETCH during reset; only the strobes need masking.
    if (rst) begin
      PC_write   = 1'b0;
      IR_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multi-cycle RISC-V core. It shares one ALU and one unified instruction/data memory across the cycles of each instruction. It sits beside the multi-cycle datapath, which holds the PC, OldPC, IR, A, B, ALUOut and Data registers. It decodes `opc`/`f3` from the IR and issues per-cycle mux selects and write strobes, with memory wait states driven by `mem_ready`.

## Interface
- No parameters. ALU_op encoding: 00 add, 01 sub, 10 R-type (funct decode), 11 I-type. imm_src encoding: 000 I, 001 S, 010 B, 011 LUI, 100 JAL.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- opc  in  7  IR[6:0]
- f3  in  3  IR[14:12]
- zero  in  1  ALU result == 0 (combinational from datapath)
- neg  in  1  ALU result sign (signed less-than)
- mem_ready  in  1  memory access completes this cycle
- PC_write  out  1  load PC from the result bus
- IR_write  out  1  load IR from memory and OldPC from PC
- adr_src  out  1  memory address: 0 = PC, 1 = result bus
- mem_write  out  1  memory write strobe
- reg_write  out  1  register file write
- ALU_src_A  out  2  00 PC, 01 OldPC, 10 A
- ALU_src_B  out  2  00 B, 01 immediate, 10 constant 4
- ALU_op  out  2  see encoding above
- result_src  out  2  00 ALUOut, 01 Data, 10 ALU result, 11 immediate
- imm_src  out  3  immediate format
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode

## Operation
- Moore-style FSM with one registered state register. All outputs are combinational from state, plus opc/f3/zero/neg/mem_ready where stated. Any output not listed for a state is 0.
- imm_src is decoded from opc in every state: SW→S, BT (1100011)→B, LUI→LUI, JAL→JAL, otherwise I.
- States and actions:
  - FETCH: adr_src=0, A=00, B=10, ALU_op=00, result_src=10. IR_write=PC_write=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
  - DECODE: A=01, B=01, ALU_op=00, so ALUOut = branch/JAL target. Next state by opc:
    - LW (0000011) or SW (0100011) → MEM_ADR
    - R (0110011) → EXEC_R
    - I (0010011) → EXEC_I
    - BT → BRANCH
    - JAL (1101111) → JAL
    - JALR (1100111) → JALR_ADR
    - LUI (0110111) → LUI
    - anything else: illegal=1, instr_done=1, → FETCH
  - MEM_ADR: A=10, B=01, ALU_op=00. Goes to MEM_READ for LW, MEM_WRITE for SW.
  - MEM_READ: adr_src=1, result_src=00. Waits for mem_ready, then → MEM_WB.
  - MEM_WB: result_src=01, reg_write=1, instr_done=1. → FETCH.
  - MEM_WRITE: adr_src=1, result_src=00, mem_write=1 held through the wait. On mem_ready: instr_done=1, → FETCH.
  - EXEC_R: A=10, B=00, ALU_op=10. → ALU_WB.
  - EXEC_I: A=10, B=01, ALU_op=11. → ALU_WB.
  - ALU_WB: result_src=00, reg_write=1, instr_done=1. → FETCH.
  - BRANCH: A=10, B=00, ALU_op=01, result_src=00. PC_write by f3:
    - 000: zero
    - 001: ~zero
    - 100: neg
    - 101: ~neg
    - other f3: 0
    - instr_done=1, → FETCH.
  - JAL: A=01, B=10, ALU_op=00, result_src=00, PC_write=1. → ALU_WB, which writes PC+4 to rd.
  - JALR_ADR: A=10, B=01, ALU_op=00. → JALR_J.
  - JALR_J: A=01, B=10, ALU_op=00, result_src=00, PC_write=1. → ALU_WB.
  - LUI: result_src=11, reg_write=1, instr_done=1. → FETCH.
- Reset: the state is forced to FETCH asynchronously. While rst=1, PC_write, IR_write, mem_write, reg_write, instr_done and illegal are all 0. Selects take their FETCH values: adr_src=0, A=00, B=10, ALU_op=00, result_src=10.
- An unreachable state encoding recovers to FETCH on the next edge with all strobes 0.

## Timing
- With mem_ready held at 1, cycles per instruction are:
  - LUI: 3
  - BT: 3
  - R, I, SW, JAL: 4
  - LW, JALR: 5
- Each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Outputs are held stable during the wait.
- The state advances on the rising edge. Strobes are valid combinationally in the current state, and the datapath samples them on the same edge.
- If rst is asserted mid-instruction, the instruction is abandoned immediately with no partial write. The first FETCH occurs in the first cycle after rst deasserts.
- instr_done fires exactly once per instruction, including illegal ones.

## Test plan
- Reset, then release with mem_ready=1: the first cycle is FETCH with IR_write=PC_write=1, A=00, B=10, result_src=10. The next cycle is DECODE.
- LW (opc=0000011) with mem_ready=0 for 2 cycles in MEM_READ: 7 cycles total. reg_write=1 only in MEM_WB with result_src=01. instr_done pulses once.
- BT with f3=000 and zero=1: PC_write=1 in BRANCH. With zero=0: PC_write=0. f3=101 with neg=1: PC_write=0. Each case takes 3 cycles.
- JALR: the sequence is FETCH, DECODE, JALR_ADR (A=10, B=01), JALR_J (PC_write=1, result_src=00), ALU_WB (reg_write=1).
- opc=1111111: illegal=1 and instr_done=1 in DECODE, no write strobe asserted, returns to FETCH.
- rst pulsed during MEM_WRITE with mem_ready=0: mem_write drops to 0 immediately, and the state after release is FETCH.
